// File: rtl/rr_read_arbiter_pkg.sv
// Shared types and constants for the round-robin AXI read arbiter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package rr_read_arbiter_pkg;
    localparam int AXI_ID_WIDTH  = 4;
    localparam int AXI_LEN_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Index width that stays at least one bit wide for a single master.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// Rotating priority encoder: first asserted request at or after i_start, wrapping.
module rr_picker
    import rr_read_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_grant,
    output logic             o_valid
);
    // Scan from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        int w_idx;
        o_grant = '0;
        o_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(i_start) + k) % N;
            if (i_req[w_idx]) begin
                o_grant = IDX_W'(w_idx);
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_read_arbiter.sv
// Arbitrates several read masters onto one AXI read port, one burst in flight at a time.
module rr_read_arbiter
    import rr_read_arbiter_pkg::*;
#(
    parameter int MASTERS    = 3,
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int FIXED_PRIO = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [MASTERS-1:0]                m_arvalid,
    output logic [MASTERS-1:0]                m_arready,
    input  logic [MASTERS*ADDR_WIDTH-1:0]     m_araddr,
    input  logic [MASTERS*AXI_LEN_WIDTH-1:0]  m_arlen,
    output logic [MASTERS-1:0]                m_rvalid,
    input  logic [MASTERS-1:0]                m_rready,
    output logic                              m_rlast,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    output logic [AXI_ID_WIDTH-1:0]           s_arid,
    output logic [AXI_LEN_WIDTH-1:0]          s_arlen,
    output logic [ADDR_WIDTH-1:0]             s_araddr,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    input  logic                              s_rlast,
    input  logic [AXI_ID_WIDTH-1:0]           s_rid,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic                              o_busy,
    output logic                              o_err
);
    localparam int IDX_W = idx_width(MASTERS);

    arb_state_t               r_state;
    arb_state_t               w_next;
    logic [IDX_W-1:0]         r_g;
    logic [IDX_W-1:0]         r_last_g;
    logic [AXI_LEN_WIDTH-1:0] r_beat_cnt;
    logic                     r_err;
    logic [IDX_W-1:0]         w_start;
    logic [IDX_W-1:0]         w_pick;
    logic                     w_pick_valid;
    logic [ADDR_WIDTH-1:0]    w_sel_addr;
    logic [AXI_LEN_WIDTH-1:0] w_sel_len;
    logic                     w_id_match;
    logic                     w_ar_hs;
    logic                     w_fwd_hs;
    logic                     w_drain_hs;

    assign w_start = (FIXED_PRIO != 0) ? '0 :
                     ((int'(r_last_g) + 1 >= MASTERS) ? '0 : r_last_g + 1'b1);

    rr_picker #(
        .N     (MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (m_arvalid),
        .i_start (w_start),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    assign w_sel_addr = m_araddr[int'(r_g)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_len  = m_arlen[int'(r_g)*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
    assign w_id_match = (s_rid == AXI_ID_WIDTH'(r_g));
    assign w_ar_hs    = (r_state == ADDR) && s_arready;
    assign w_fwd_hs   = (r_state == DATA) && s_rvalid && w_id_match && m_rready[r_g];
    assign w_drain_hs = (r_state == DATA) && s_rvalid && !w_id_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid)         w_next = ADDR;
            ADDR:    if (s_arready)            w_next = DATA;
            DATA:    if (w_fwd_hs && s_rlast)  w_next = IDLE;
            default:                           w_next = IDLE;
        endcase
    end

    // Beat counter mismatches against s_rlast flag a protocol error but never stall the burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g        <= '0;
            r_last_g   <= IDX_W'(MASTERS - 1);
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == IDLE && w_pick_valid) r_g <= w_pick;
            if (w_ar_hs)
                r_beat_cnt <= w_sel_len;
            else if (w_fwd_hs && r_beat_cnt != '0)
                r_beat_cnt <= r_beat_cnt - 1'b1;
            if (w_fwd_hs && s_rlast) r_last_g <= r_g;
            if (w_drain_hs || (w_fwd_hs && (s_rlast != (r_beat_cnt == '0))))
                r_err <= 1'b1;
        end
    end

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        s_arvalid = 1'b0;
        s_arid    = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_rready  = 1'b0;
        m_rdata   = '0;
        m_rlast   = 1'b0;
        case (r_state)
            ADDR: begin
                s_arvalid      = 1'b1;
                s_arid         = AXI_ID_WIDTH'(r_g);
                s_araddr       = w_sel_addr;
                s_arlen        = w_sel_len;
                m_arready[r_g] = s_arready;
            end
            DATA: begin
                m_rvalid[r_g] = s_rvalid && w_id_match;
                s_rready      = w_id_match ? m_rready[r_g] : 1'b1;
                m_rdata       = s_rdata;
                m_rlast       = s_rlast;
            end
            default: ;
        endcase
    end

    assign o_busy = (r_state != IDLE);
    assign o_err  = r_err;
endmodule

// File: tb/tb_rr_read_arbiter.sv
// Randomized bench for rr_read_arbiter: round-robin and fixed-priority instances share stimulus.
`timescale 1ns/1ps
module tb_rr_read_arbiter;
    import rr_read_arbiter_pkg::*;

    localparam int M  = 3;
    localparam int AW = 26;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n_a, rst_n_b, use_fp;

    // ---------------- shared stimulus ----------------
    logic [M-1:0]    m_arvalid, m_rready;
    logic [M*AW-1:0] m_araddr;
    logic [M*4-1:0]  m_arlen;
    logic            s_arready, s_rvalid, s_rlast;
    logic [3:0]      s_rid;
    logic [DW-1:0]   s_rdata;

    // ---------------- per-instance outputs ----------------
    logic [M-1:0]  a_arready, b_arready, a_rvalid, b_rvalid;
    logic          a_rlast, b_rlast, a_arvalid, b_arvalid, a_rready, b_rready;
    logic          a_busy, b_busy, a_err, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [3:0]    a_arid, b_arid, a_arlen, b_arlen;
    logic [AW-1:0] a_araddr, b_araddr;

    // The instance not under test is held in reset; this is the view of the active one.
    logic [M-1:0]  m_arready, m_rvalid;
    logic          m_rlast, s_arvalid, s_rready, o_busy, o_err;
    logic [DW-1:0] m_rdata;
    logic [3:0]    s_arid, s_arlen;
    logic [AW-1:0] s_araddr;
    assign m_arready = use_fp ? b_arready : a_arready;
    assign m_rvalid  = use_fp ? b_rvalid  : a_rvalid;
    assign m_rlast   = use_fp ? b_rlast   : a_rlast;
    assign m_rdata   = use_fp ? b_rdata   : a_rdata;
    assign s_arvalid = use_fp ? b_arvalid : a_arvalid;
    assign s_arid    = use_fp ? b_arid    : a_arid;
    assign s_arlen   = use_fp ? b_arlen   : a_arlen;
    assign s_araddr  = use_fp ? b_araddr  : a_araddr;
    assign s_rready  = use_fp ? b_rready  : a_rready;
    assign o_busy    = use_fp ? b_busy    : a_busy;
    assign o_err     = use_fp ? b_err     : a_err;

    rr_read_arbiter #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n_a),
        .m_arvalid(m_arvalid), .m_arready(a_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(a_rvalid), .m_rready(m_rready), .m_rlast(a_rlast), .m_rdata(a_rdata),
        .s_arvalid(a_arvalid), .s_arready(s_arready), .s_arid(a_arid), .s_arlen(a_arlen),
        .s_araddr(a_araddr), .s_rvalid(s_rvalid), .s_rready(a_rready), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rdata(s_rdata), .o_busy(a_busy), .o_err(a_err)
    );

    rr_read_arbiter #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n_b),
        .m_arvalid(m_arvalid), .m_arready(b_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(b_rvalid), .m_rready(m_rready), .m_rlast(b_rlast), .m_rdata(b_rdata),
        .s_arvalid(b_arvalid), .s_arready(s_arready), .s_arid(b_arid), .s_arlen(b_arlen),
        .s_araddr(b_araddr), .s_rvalid(s_rvalid), .s_rready(b_rready), .s_rlast(s_rlast),
        .s_rid(s_rid), .s_rdata(s_rdata), .o_busy(b_busy), .o_err(b_err)
    );

    // ---------------- scoreboard / reference model ----------------
    int            n_checks = 0;
    int            n_errors = 0;
    int            model_last;
    bit            model_err;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    // Winner by the arbitration rule: lowest index, or first index after the last winner.
    function automatic int model_pick(input logic [M-1:0] mask);
        int start;
        start = use_fp ? 0 : (model_last + 1) % M;
        for (int k = 0; k < M; k++)
            if (mask[(start + k) % M]) return (start + k) % M;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {m_arready, m_rvalid, s_arvalid, s_rready, o_busy, o_err,
                            m_rlast, s_arid, s_arlen}, 64'd0);
        chk({tag, "_data"}, {s_araddr, m_rdata}, 64'd0);
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_rready = '0; s_arready = 1'b0;
        s_rvalid = 1'b0; s_rlast = 1'b0; s_rid = '0; s_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk_zero("reset");
        tick();
        if (use_fp) rst_n_b = 1'b1; else rst_n_a = 1'b1;
        model_last = M - 1;
        model_err  = 1'b0;
        tick();
    endtask

    task automatic rand_fields();
        for (int i = 0; i < M; i++) begin
            m_araddr[i*AW +: AW] = AW'($urandom);
            m_arlen[i*4 +: 4]    = 4'($urandom_range(0, 3));
        end
    endtask

    // Runs one complete burst; called and returns at posedge+1 with the DUT in IDLE.
    task automatic run_burst(input logic [M-1:0] mask, input logic [DW-1:0] base,
                             input int early_last, input int bad_at, input int rst_after,
                             input bit keep_req, output int got);
        int g, len, stall, b, cyc;
        bit done, inject, fwd, bad_done;
        logic [DW-1:0] exp_d;
        g   = model_pick(mask);
        len = int'(m_arlen[g*4 +: 4]);
        got = -1;
        exp_q.delete();
        for (int i = 0; i <= len; i++) exp_q.push_back(base + DW'(i));

        m_arvalid = mask;
        s_arready = 1'b0;
        @(negedge clk);
        chk("idle_arvalid", s_arvalid, 0);
        chk("idle_busy", o_busy, 0);
        chk("err_flag", o_err, model_err);
        tick();

        stall = $urandom_range(0, 2);
        for (int k = 0; k <= stall; k++) begin
            s_arready = (k == stall);
            @(negedge clk);
            chk("addr_arvalid", s_arvalid, 1);
            chk("addr_arid", s_arid, 64'(g));
            chk("addr_araddr", s_araddr, m_araddr[g*AW +: AW]);
            chk("addr_arlen", s_arlen, m_arlen[g*4 +: 4]);
            chk("addr_arready", m_arready, s_arready ? (M'(1) << g) : M'(0));
            chk("addr_rready", s_rready, 0);
            got = int'(s_arid);
            tick();
        end
        s_arready = 1'b0;
        if (!keep_req) m_arvalid = '0;

        b = 0; cyc = 0; done = 0; bad_done = 0;
        while (!done) begin
            if (b == rst_after) begin
                s_rvalid = 1'b1; s_rid = 4'(g); s_rdata = base + DW'(b); s_rlast = 1'b0;
                m_rready = '1;
                if (use_fp) rst_n_b = 1'b0; else rst_n_a = 1'b0;
                #1;
                chk_zero("mid_reset");
                clear_inputs();
                tick();
                if (use_fp) rst_n_b = 1'b1; else rst_n_a = 1'b1;
                model_last = M - 1;
                model_err  = 1'b0;
                tick();
                return;
            end
            inject   = (b == bad_at) && !bad_done;
            m_rready = M'($urandom);
            if (inject) begin
                s_rvalid = 1'b1; s_rid = 4'((g + 1) % M); s_rdata = $urandom; s_rlast = 1'b0;
                m_rready[g] = 1'b0;
            end else begin
                s_rvalid = ($urandom_range(0, 3) != 0);
                s_rid    = 4'(g);
                s_rdata  = base + DW'(b);
                s_rlast  = (b == len) || (b == early_last);
            end
            fwd = !inject && s_rvalid && m_rready[g];
            @(negedge clk);
            chk("data_busy", o_busy, 1);
            if (inject) begin
                chk("drain_rvalid", m_rvalid, 0);
                chk("drain_rready", s_rready, 1);
                model_err = 1'b1;
                bad_done  = 1'b1;
            end else begin
                chk("data_rvalid", m_rvalid, s_rvalid ? (M'(1) << g) : M'(0));
                chk("data_rready", s_rready, m_rready[g]);
                if (fwd) begin
                    exp_d = exp_q.pop_front();
                    chk("data_rdata", m_rdata, exp_d);
                    chk("data_rlast", m_rlast, (b == len) || (b == early_last));
                    if (s_rlast && b != len) model_err = 1'b1;
                end
            end
            tick();
            if (fwd) begin
                if (s_rlast) done = 1;
                b++;
            end
            cyc++;
            if (!done && cyc > 300) begin
                chk("beat_timeout", 1, 0);
                done = 1;
            end
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
        model_last = g;
    endtask

    // ---------------- test sequence ----------------
    int got;
    int rr_order[5] = '{0, 1, 2, 0, 1};

    initial begin
        use_fp = 1'b0; rst_n_a = 1'b0; rst_n_b = 1'b0;
        m_araddr = '0; m_arlen = '0;
        clear_inputs();
        apply_reset();

        // single directed burst from master 0
        m_araddr[0 +: AW] = 26'h100;
        m_arlen[0 +: 4]   = 4'd3;
        run_burst(3'b001, 32'hA, -1, -1, -1, 0, got);
        chk("dir_grant", got, 0);
        @(negedge clk);
        chk("dir_busy_done", o_busy, 0);
        chk("dir_err", o_err, 0);
        tick();

        // round-robin order under continuous requests
        apply_reset();
        rand_fields();
        m_arlen = '0;
        for (int i = 0; i < 5; i++) begin
            run_burst(3'b111, $urandom, -1, -1, -1, 1, got);
            chk("rr_order", got, rr_order[i]);
        end
        m_arvalid = '0;
        tick();

        // early s_rlast, then a stray-id beat; error stays sticky
        m_arlen[0 +: 4] = 4'd3;
        m_arlen[4 +: 4] = 4'd3;
        run_burst(3'b001, $urandom, 2, -1, -1, 0, got);
        @(negedge clk);
        chk("early_last_err", o_err, 1);
        chk("early_last_idle", o_busy, 0);
        tick();
        run_burst(3'b010, $urandom, -1, 1, -1, 0, got);
        chk("bad_id_grant", got, 1);
        @(negedge clk);
        chk("bad_id_err_sticky", o_err, 1);
        tick();
        apply_reset();

        // reset in the middle of a burst, then next grant goes to master 0
        m_arlen[0 +: 4] = 4'd3;
        run_burst(3'b001, $urandom, -1, -1, 2, 0, got);
        run_burst(3'b111, $urandom, -1, -1, -1, 0, got);
        chk("post_reset_grant", got, 0);

        // randomized round-robin traffic
        for (int i = 0; i < 20; i++) begin
            rand_fields();
            run_burst(M'($urandom_range(1, 7)), $urandom, -1, -1, -1, 1'($urandom), got);
        end
        m_arvalid = '0;
        tick();

        // fixed-priority instance
        use_fp = 1'b1;
        apply_reset();
        m_arlen = '0;
        for (int i = 0; i < 5; i++) begin
            run_burst(3'b111, $urandom, -1, -1, -1, 1, got);
            chk("fp_grant", got, 0);
        end
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            run_burst(M'($urandom_range(1, 7)), $urandom, -1, -1, -1, 1'($urandom), got);
        end
        m_arvalid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
